// File: rtl/lc4_issue_ctrl.sv
// LC4 issue controller: fixed four-cycle fetch/decode/exec/writeback sequencer
// that feeds lc4_alu and commits its result to the regfile, PC, carry and NZP.
module lc4_issue_ctrl #(
   parameter int unsigned WORD_SIZE = 64,
   parameter int unsigned DADDR     = 4,
   parameter int unsigned INSN      = 19,
   parameter int unsigned IADDR     = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_run,
   output logic [IADDR:0]       o_imem_addr,
   input  logic [INSN:0]        i_imem_data,
   output logic [DADDR-1:0]     o_rs_sel,
   output logic [DADDR-1:0]     o_rt_sel,
   output logic [INSN:0]        o_alu_insn,
   output logic [IADDR:0]       o_alu_pc,
   output logic                 o_alu_carry,
   input  logic [WORD_SIZE-1:0] i_alu_result,
   output logic                 o_rf_we,
   output logic [DADDR-1:0]     o_rf_waddr,
   output logic [WORD_SIZE-1:0] o_rf_wdata,
   output logic                 o_halted,
   output logic                 o_illegal
);

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_BRZ  = 5'b00001;
   localparam logic [4:0] OP_BRZP = 5'b00010;
   localparam logic [4:0] OP_BRNP = 5'b00011;
   localparam logic [4:0] OP_BRNZ = 5'b00100;
   localparam logic [4:0] OP_JSR  = 5'b01000;
   localparam logic [4:0] OP_RTI  = 5'b01010;
   localparam logic [4:0] OP_CHK  = 5'b10000;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

   state_t               state_q, state_d;
   logic [IADDR:0]       pc_q, pc_d;
   logic [INSN:0]        ir_q, ir_d;
   logic                 carry_q, carry_d;
   logic [2:0]           nzp_q, nzp_d;
   logic [WORD_SIZE-1:0] res_q, res_d;
   logic                 rf_we_q, rf_we_d;
   logic [DADDR-1:0]     rf_waddr_q, rf_waddr_d;
   logic [WORD_SIZE-1:0] rf_wdata_q, rf_wdata_d;
   logic                 halted_q, halted_d;
   logic                 illegal_q, illegal_d;

   logic [4:0]     opcode;
   logic [IADDR:0] pc_inc;
   logic           br_taken;

   function automatic logic is_alu_wr(input logic [4:0] op);
      case (op)
         5'b00101, 5'b00110, 5'b00111, 5'b01001, 5'b01011, 5'b01100, 5'b01101,
         5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10100, 5'b10101: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign opcode = ir_q[19:15];
   assign pc_inc = pc_q + (IADDR+1)'(1);

   always_comb begin
      case (opcode)
         OP_BRZ:  br_taken = nzp_q[1];
         OP_BRZP: br_taken = nzp_q[1] | nzp_q[0];
         OP_BRNP: br_taken = nzp_q[2] | nzp_q[0];
         OP_BRNZ: br_taken = nzp_q[2] | nzp_q[1];
         default: br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= '0;
         ir_q       <= '0;
         carry_q    <= 1'b0;
         nzp_q      <= 3'b010;
         res_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         halted_q   <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         carry_q    <= carry_d;
         nzp_q      <= nzp_d;
         res_q      <= res_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         halted_q   <= halted_d;
         illegal_q  <= illegal_d;
      end
   end

   // Write port is loaded at the end of EXEC so it is presented during WB.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      carry_d    = carry_q;
      nzp_d      = nzp_q;
      res_d      = res_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      halted_d   = halted_q;
      illegal_d  = illegal_q;
      case (state_q)
         S_FETCH: begin
            if (i_run) state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d    = i_imem_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d   = i_alu_result;
            state_d = S_WB;
            if (is_alu_wr(opcode)) begin
               rf_we_d    = 1'b1;
               rf_waddr_d = ir_q[14:11];
               rf_wdata_d = i_alu_result;
            end else if (opcode == OP_JSR) begin
               rf_we_d    = 1'b1;
               rf_waddr_d = {DADDR{1'b1}};
               rf_wdata_d = WORD_SIZE'(pc_inc);
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            case (opcode)
               OP_NOP: pc_d = pc_inc;
               OP_RTI, OP_JSR: pc_d = res_q[IADDR:0];
               OP_BRZ, OP_BRZP, OP_BRNP, OP_BRNZ:
                  pc_d = br_taken ? res_q[IADDR:0] : pc_inc;
               OP_CHK: begin
                  carry_d = res_q[0];
                  pc_d    = pc_inc;
               end
               OP_HALT: begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
               default: begin
                  if (is_alu_wr(opcode)) begin
                     pc_d = pc_inc;
                     if (res_q[WORD_SIZE-1])   nzp_d = 3'b100;
                     else if (res_q == '0)     nzp_d = 3'b010;
                     else                      nzp_d = 3'b001;
                  end else begin
                     illegal_d = 1'b1;
                     state_d   = S_HALT;
                  end
               end
            endcase
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Register selects follow imem data in DECODE so regfile data lands in EXEC.
   assign o_rs_sel    = (state_q == S_DECODE) ? i_imem_data[10:7] : ir_q[10:7];
   assign o_rt_sel    = (state_q == S_DECODE) ? i_imem_data[3:0]  : ir_q[3:0];
   assign o_imem_addr = pc_q;
   assign o_alu_insn  = ir_q;
   assign o_alu_pc    = pc_q;
   assign o_alu_carry = carry_q;
   assign o_rf_we     = rf_we_q;
   assign o_rf_waddr  = rf_waddr_q;
   assign o_rf_wdata  = rf_wdata_q;
   assign o_halted    = halted_q;
   assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_lc4_issue_ctrl.sv
// Self-checking bench for lc4_issue_ctrl: instruction-level reference model
// with directed scenarios and randomized legal instruction streams.
module tb_lc4_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_run;
   logic [10:0] o_imem_addr;
   logic [19:0] i_imem_data;
   logic [3:0]  o_rs_sel, o_rt_sel;
   logic [19:0] o_alu_insn;
   logic [10:0] o_alu_pc;
   logic        o_alu_carry;
   logic [63:0] i_alu_result;
   logic        o_rf_we;
   logic [3:0]  o_rf_waddr;
   logic [63:0] o_rf_wdata;
   logic        o_halted, o_illegal;

   logic [19:0] imem [0:2047];
   logic [19:0] imem_q;

   int checks = 0;
   int errors = 0;

   logic [10:0] m_pc;
   logic        m_carry;
   logic [2:0]  m_nzp;
   logic        m_halted, m_illegal;

   logic [4:0] legal_ops [0:20] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b01000, 5'b01010, 5'b10000, 5'b00101, 5'b00110, 5'b00111, 5'b01001, 5'b01011,
      5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10100, 5'b10101};

   always #5 clk = ~clk;

   always @(posedge clk) imem_q <= imem[o_imem_addr];
   assign i_imem_data = imem_q;

   lc4_issue_ctrl dut (
      .clk(clk), .rst(rst), .i_run(i_run),
      .o_imem_addr(o_imem_addr), .i_imem_data(i_imem_data),
      .o_rs_sel(o_rs_sel), .o_rt_sel(o_rt_sel),
      .o_alu_insn(o_alu_insn), .o_alu_pc(o_alu_pc), .o_alu_carry(o_alu_carry),
      .i_alu_result(i_alu_result),
      .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
      .o_halted(o_halted), .o_illegal(o_illegal)
   );

   function automatic logic [19:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt);
      return {op, rd, rs, 3'b000, rt};
   endfunction

   task automatic model_reset();
      m_pc = '0; m_carry = 1'b0; m_nzp = 3'b010; m_halted = 1'b0; m_illegal = 1'b0;
   endtask

   // Drives one instruction through all four cycles and checks each stage.
   task automatic run_insn(input logic [19:0] insn, input logic [63:0] r);
      logic [4:0]  op;
      logic        alu_wr, legal, taken, exp_we;
      logic [3:0]  exp_wa;
      logic [63:0] exp_wd;
      logic [10:0] link, npc;
      op = insn[19:15];
      imem[m_pc] = insn;
      i_alu_result = r;
      i_run = 1'b1;
      alu_wr = op inside {5'b00101, 5'b00110, 5'b00111, 5'b01001, 5'b01011, 5'b01100,
                          5'b01101, 5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10100, 5'b10101};
      legal = alu_wr || (op inside {5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                    5'b01000, 5'b01010, 5'b10000, 5'b11111});
      link = m_pc + 11'd1;

      checks++;
      if (o_imem_addr !== m_pc) begin
         errors++; $display("FAIL fetch_addr got %0d want %0d", o_imem_addr, m_pc);
      end
      @(negedge clk);
      checks++;
      if (o_rs_sel !== insn[10:7] || o_rt_sel !== insn[3:0]) begin
         errors++; $display("FAIL decode_sel got rs=%0d rt=%0d want rs=%0d rt=%0d",
                            o_rs_sel, o_rt_sel, insn[10:7], insn[3:0]);
      end
      @(negedge clk);
      checks++;
      if (o_alu_insn !== insn || o_alu_pc !== m_pc || o_alu_carry !== m_carry) begin
         errors++; $display("FAIL exec_alu_in got insn=%h pc=%0d c=%0b want insn=%h pc=%0d c=%0b",
                            o_alu_insn, o_alu_pc, o_alu_carry, insn, m_pc, m_carry);
      end
      @(negedge clk);
      exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
      if (alu_wr) begin exp_we = 1'b1; exp_wa = insn[14:11]; exp_wd = r; end
      if (op == 5'b01000) begin exp_we = 1'b1; exp_wa = 4'd15; exp_wd = 64'(link); end
      checks++;
      if (o_rf_we !== exp_we || (exp_we && (o_rf_waddr !== exp_wa || o_rf_wdata !== exp_wd))) begin
         errors++; $display("FAIL wb_write op=%b got we=%0b wa=%0d wd=%h want we=%0b wa=%0d wd=%h",
                            op, o_rf_we, o_rf_waddr, o_rf_wdata, exp_we, exp_wa, exp_wd);
      end

      taken = (op == 5'b00001 && m_nzp == 3'b010) || (op == 5'b00010 && m_nzp != 3'b100) ||
              (op == 5'b00011 && m_nzp != 3'b010) || (op == 5'b00100 && m_nzp != 3'b001);
      npc = link;
      if (op == 5'b01010 || op == 5'b01000 || taken) npc = r[10:0];
      if (alu_wr) m_nzp = ($signed(r) < 64'sd0) ? 3'b100 : (r == 64'd0) ? 3'b010 : 3'b001;
      if (op == 5'b10000) m_carry = r[0];
      if (op == 5'b11111) begin m_halted = 1'b1; npc = m_pc; end
      else if (!legal) begin m_illegal = 1'b1; npc = m_pc; end
      m_pc = npc;

      @(negedge clk);
      checks++;
      if (o_imem_addr !== m_pc || o_rf_we !== 1'b0 || o_halted !== m_halted ||
          o_illegal !== m_illegal) begin
         errors++; $display("FAIL commit op=%b got pc=%0d we=%0b h=%0b il=%0b want pc=%0d we=0 h=%0b il=%0b",
                            op, o_imem_addr, o_rf_we, o_halted, o_illegal, m_pc, m_halted, m_illegal);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; i_run = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({o_imem_addr, o_rs_sel, o_rt_sel, o_alu_insn, o_alu_pc, o_alu_carry, o_rf_we,
           o_rf_waddr, o_rf_wdata, o_halted, o_illegal} !== '0) begin
         errors++; $display("FAIL reset_outputs got pc=%0d ir=%h we=%0b wd=%h h=%0b il=%0b want all zero",
                            o_imem_addr, o_alu_insn, o_rf_we, o_rf_wdata, o_halted, o_illegal);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_const();
      run_insn(mk(5'b01001, 4'd2, 4'd0, 4'd0), {64{1'b1}});
      run_insn(mk(5'b00001, 4'd0, 4'd0, 4'd0), 64'd20);
      checks++;
      if (o_imem_addr !== 11'd2) begin
         errors++; $display("FAIL brz_not_taken_after_neg got %0d want 2", o_imem_addr);
      end
      run_insn(mk(5'b00100, 4'd0, 4'd0, 4'd0), 64'd20);
      checks++;
      if (o_imem_addr !== 11'd20) begin
         errors++; $display("FAIL brnz_taken_after_neg got %0d want 20", o_imem_addr);
      end
   endtask

   task automatic test_branch();
      run_insn(mk(5'b01010, 4'd0, 4'd0, 4'd0), 64'd4);
      run_insn(mk(5'b00101, 4'd1, 4'd2, 4'd3), 64'd0);
      run_insn(mk(5'b00001, 4'd0, 4'd0, 4'd0), 64'd8);
      checks++;
      if (o_imem_addr !== 11'd8) begin
         errors++; $display("FAIL brz_taken got %0d want 8", o_imem_addr);
      end
      run_insn(mk(5'b01010, 4'd0, 4'd0, 4'd0), 64'd4);
      run_insn(mk(5'b00101, 4'd1, 4'd2, 4'd3), 64'd7);
      run_insn(mk(5'b00001, 4'd0, 4'd0, 4'd0), 64'd8);
      checks++;
      if (o_imem_addr !== 11'd6) begin
         errors++; $display("FAIL brz_not_taken got %0d want 6", o_imem_addr);
      end
   endtask

   task automatic test_jsr();
      run_insn(mk(5'b01010, 4'd0, 4'd0, 4'd0), 64'd10);
      imem[m_pc] = mk(5'b01000, 4'd0, 4'd0, 4'd0);
      i_alu_result = 64'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (o_rf_we !== 1'b1 || o_rf_waddr !== 4'd15 || o_rf_wdata !== 64'd11) begin
         errors++; $display("FAIL jsr_link got we=%0b wa=%0d wd=%0d want we=1 wa=15 wd=11",
                            o_rf_we, o_rf_waddr, o_rf_wdata);
      end
      @(negedge clk);
      checks++;
      if (o_imem_addr !== 11'd0) begin
         errors++; $display("FAIL jsr_target got %0d want 0", o_imem_addr);
      end
      m_pc = 11'd0;
   endtask

   task automatic test_chk();
      run_insn(mk(5'b10000, 4'd3, 4'd1, 4'd0), 64'h1);
      run_insn(mk(5'b00000, 4'd0, 4'd0, 4'd0), 64'd0);
      checks++;
      if (o_alu_carry !== 1'b1) begin
         errors++; $display("FAIL chk_carry got %0b want 1", o_alu_carry);
      end
   endtask

   task automatic test_wrap_hold();
      logic [10:0] held;
      run_insn(mk(5'b01010, 4'd0, 4'd0, 4'd0), 64'd2047);
      run_insn(mk(5'b00000, 4'd0, 4'd0, 4'd0), 64'd0);
      checks++;
      if (o_imem_addr !== 11'd0) begin
         errors++; $display("FAIL pc_wrap got %0d want 0", o_imem_addr);
      end
      i_run = 1'b0;
      held = m_pc;
      imem[m_pc] = mk(5'b00101, 4'd5, 4'd0, 4'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (o_imem_addr !== held || o_rf_we !== 1'b0 || o_alu_insn !== 20'd0) begin
            errors++; $display("FAIL run_hold cyc=%0d got pc=%0d we=%0b ir=%h want pc=%0d we=0 ir=0",
                               i, o_imem_addr, o_rf_we, o_alu_insn, held);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0]  op;
      logic [63:0] r;
      for (int n = 0; n < 60; n++) begin
         op = legal_ops[$urandom_range(0, 20)];
         case ($urandom_range(0, 3))
            0:       r = 64'd0;
            1:       r = {1'b1, 31'($urandom), 32'($urandom)};
            default: r = {1'b0, 31'($urandom), 32'($urandom)};
         endcase
         run_insn(mk(op, 4'($urandom), 4'($urandom), 4'($urandom)), r);
      end
   endtask

   task automatic test_reset_mid();
      imem[m_pc] = mk(5'b00110, 4'd7, 4'd1, 4'd2);
      i_alu_result = 64'h55;
      i_run = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1; i_run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      checks++;
      if (o_rf_we !== 1'b0 || o_imem_addr !== 11'd0 || o_alu_insn !== 20'd0) begin
         errors++; $display("FAIL rst_mid got we=%0b pc=%0d ir=%h want we=0 pc=0 ir=0",
                            o_rf_we, o_imem_addr, o_alu_insn);
      end
      @(negedge clk);
      checks++;
      if (o_rf_we !== 1'b0 || o_imem_addr !== 11'd0) begin
         errors++; $display("FAIL rst_mid_after got we=%0b pc=%0d want we=0 pc=0", o_rf_we, o_imem_addr);
      end
   endtask

   task automatic test_stop(input logic [4:0] op);
      logic [10:0] held;
      run_insn(mk(op, 4'd1, 4'd1, 4'd1), 64'd33);
      held = m_pc;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (o_imem_addr !== held || o_rf_we !== 1'b0 || o_halted !== (op == 5'b11111) ||
             o_illegal !== (op != 5'b11111)) begin
            errors++; $display("FAIL stop_absorb op=%b cyc=%0d got pc=%0d we=%0b h=%0b il=%0b",
                               op, i, o_imem_addr, o_rf_we, o_halted, o_illegal);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) imem[i] = '0;
      rst = 1'b1; i_run = 1'b0; i_alu_result = '0;
      model_reset();
      test_reset();
      test_const();
      test_branch();
      test_jsr();
      test_chk();
      test_wrap_hold();
      test_random();
      test_reset_mid();
      test_random();
      test_stop(5'b11110);
      test_reset();
      test_stop(5'b11111);
      test_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
